cgra_issue_ctrl: RTL

- Instruction sequencer for one CGRA lane.
- Fetches 32-bit RISC-V-subset instructions from a synchronous instruction memory and holds the current instruction stable for the ISA decoder.
- Issues scalar instructions in one cycle. Sequences vector instructions element by element over the vector length set by vsetivli, with AXI-stream flow control on the stream-in (vle32/vmacc) and stream-out (vse32) paths.
- Resolves beq branches and halts on ecall.

---
 rtl/cgra_isa_pkg.sv | 67 ++++++
 rtl/cgra_branch_target.sv | 19 +
 rtl/cgra_issue_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cgra_isa_pkg.sv
// Shared ISA definitions for the CGRA lane: opcode fields, instruction classes,
// issue-controller states and the instruction classifier.
package cgra_isa_pkg;

  localparam logic [6:0] OP_VLE32  = 7'h07;
  localparam logic [6:0] OP_VSE32  = 7'h27;
  localparam logic [6:0] OP_VARITH = 7'h57;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_ADDI   = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;

  localparam logic [2:0] F3_VMACC    = 3'd0;
  localparam logic [2:0] F3_VMV      = 3'd5;
  localparam logic [2:0] F3_VSETIVLI = 3'd7;
  localparam logic [2:0] F3_BEQ      = 3'd0;
  localparam logic [2:0] F3_ADDI     = 3'd0;

  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

  typedef enum logic [3:0] {
    IC_NOP,
    IC_SCALAR,
    IC_VSETIVLI,
    IC_BEQ,
    IC_ECALL,
    IC_VLE32,
    IC_VSE32,
    IC_VMACC,
    IC_VMV
  } iclass_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_VEXEC
  } state_e;

  // ecall is matched on the full word; any other 0x73 encoding is a NOP.
  function automatic iclass_e classify(input logic [31:0] instr);
    iclass_e c;
    c = IC_NOP;
    if (instr == INSTR_ECALL) begin
      c = IC_ECALL;
    end else begin
      case (instr[6:0])
        OP_LUI:    c = IC_SCALAR;
        OP_ADDI:   if (instr[14:12] == F3_ADDI) c = IC_SCALAR;
        OP_VLE32:  c = IC_VLE32;
        OP_VSE32:  c = IC_VSE32;
        OP_BRANCH: if (instr[14:12] == F3_BEQ) c = IC_BEQ;
        OP_VARITH: begin
          case (instr[14:12])
            F3_VMACC:    c = IC_VMACC;
            F3_VMV:      c = IC_VMV;
            F3_VSETIVLI: c = IC_VSETIVLI;
            default:     c = IC_NOP;
          endcase
        end
        default:   c = IC_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/cgra_branch_target.sv
// Branch immediate extraction, sign extension and PC adders (target and pc+4).
// Arithmetic wraps modulo 2^PC_W.
module cgra_branch_target #(
  parameter int PC_W = 12
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic [6:0]      i_imm_hi,   // instr[31:25]
  input  logic [4:0]      i_imm_lo,   // instr[11:7]
  output logic [PC_W-1:0] o_pc_plus4,
  output logic [PC_W-1:0] o_target
);

  logic signed [12:0] w_imm;

  assign w_imm      = {i_imm_hi[6], i_imm_lo[0], i_imm_hi[5:0], i_imm_lo[4:1], 1'b0};
  assign o_pc_plus4 = i_pc + PC_W'(4);
  assign o_target   = i_pc + PC_W'(32'(w_imm));

endmodule

// File: rtl/cgra_issue_ctrl.sv
// Instruction sequencer for one CGRA lane: fetch/decode/exec of scalar ops,
// element-by-element vector issue with AXI-stream flow control, beq and ecall.
module cgra_issue_ctrl
  import cgra_isa_pkg::*;
#(
  parameter int PC_W         = 12,
  parameter int dwidth_inst  = 32,
  parameter int dwidth_RFadd = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [PC_W-1:0]         start_pc,
  output logic                    imem_en,
  output logic [PC_W-3:0]         imem_addr,
  input  logic [dwidth_inst-1:0]  imem_rdata,
  output logic [dwidth_inst-1:0]  instr,
  input  logic                    br_eq,
  output logic                    exec_scalar,
  output logic                    elem_fire,
  output logic [dwidth_RFadd-1:0] elem_idx,
  output logic [dwidth_RFadd-1:0] vlen,
  output logic                    s_tready,
  input  logic                    s_tvalid,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [PC_W-1:0]         pc,
  output logic                    busy,
  output logic                    done,
  output state_e                  dbg_state
);

  state_e                  r_state;
  state_e                  w_next_state;
  logic [PC_W-1:0]         r_pc;
  logic [dwidth_inst-1:0]  r_instr;
  logic [dwidth_RFadd-1:0] r_vlen;
  logic [dwidth_RFadd-1:0] r_elem_idx;
  iclass_e                 w_class;
  logic [PC_W-1:0]         w_pc_plus4;
  logic [PC_W-1:0]         w_br_target;
  logic                    w_is_vec;
  logic                    w_vlen_zero;
  logic                    w_last_elem;
  logic                    w_unused;

  assign w_class     = classify(r_instr);
  assign w_is_vec    = (w_class == IC_VLE32) || (w_class == IC_VSE32) ||
                       (w_class == IC_VMACC) || (w_class == IC_VMV);
  assign w_vlen_zero = (r_vlen == '0);
  assign w_last_elem = (r_elem_idx == r_vlen - dwidth_RFadd'(1));
  assign w_unused    = &{1'b0, start_pc[1:0]};

  cgra_branch_target #(.PC_W(PC_W)) u_branch_target (
    .i_pc       (r_pc),
    .i_imm_hi   (r_instr[31:25]),
    .i_imm_lo   (r_instr[11:7]),
    .o_pc_plus4 (w_pc_plus4),
    .o_target   (w_br_target)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next_state = ST_FETCH;
      ST_FETCH:  w_next_state = ST_DECODE;
      ST_DECODE: w_next_state = ST_EXEC;
      ST_EXEC: begin
        if (w_class == IC_ECALL)          w_next_state = ST_IDLE;
        else if (w_is_vec && !w_vlen_zero) w_next_state = ST_VEXEC;
        else                               w_next_state = ST_FETCH;
      end
      ST_VEXEC:  if (elem_fire && w_last_elem) w_next_state = ST_FETCH;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Stream handshakes: a beat transfers on a cycle where valid && ready.
  // m_tvalid, once raised for a vse32 element, stays high until m_tready
  // accepts it; s_tready is offered only while a vle32/vmacc is in VEXEC.
  always_comb begin
    imem_en     = 1'b0;
    exec_scalar = 1'b0;
    done        = 1'b0;
    s_tready    = 1'b0;
    m_tvalid    = 1'b0;
    elem_fire   = 1'b0;
    case (r_state)
      ST_FETCH: imem_en = 1'b1;
      ST_EXEC: begin
        exec_scalar = (w_class == IC_SCALAR);
        done        = (w_class == IC_ECALL);
      end
      ST_VEXEC: begin
        case (w_class)
          IC_VLE32, IC_VMACC: begin
            s_tready  = 1'b1;
            elem_fire = s_tvalid;
          end
          IC_VSE32: begin
            m_tvalid  = 1'b1;
            elem_fire = m_tready;
          end
          IC_VMV:  elem_fire = 1'b1;
          default: elem_fire = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= '0;
      r_instr    <= '0;
      r_vlen     <= '0;
      r_elem_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE:   if (start) r_pc <= {start_pc[PC_W-1:2], 2'b00};
        ST_DECODE: r_instr <= imem_rdata;
        ST_EXEC: begin
          case (w_class)
            IC_ECALL: ;
            IC_VSETIVLI: begin
              r_vlen <= dwidth_RFadd'(r_instr[29:18]);
              r_pc   <= w_pc_plus4;
            end
            IC_BEQ:   r_pc <= br_eq ? w_br_target : w_pc_plus4;
            IC_VLE32, IC_VSE32, IC_VMACC, IC_VMV: begin
              if (w_vlen_zero) r_pc <= w_pc_plus4;
              else             r_elem_idx <= '0;
            end
            default:  r_pc <= w_pc_plus4;
          endcase
        end
        ST_VEXEC: begin
          if (elem_fire) begin
            if (w_last_elem) begin
              r_pc       <= w_pc_plus4;
              r_elem_idx <= '0;
            end else begin
              r_elem_idx <= r_elem_idx + dwidth_RFadd'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = r_pc[PC_W-1:2];
  assign instr     = r_instr;
  assign pc        = r_pc;
  assign vlen      = r_vlen;
  assign elem_idx  = r_elem_idx;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule
